// File: rtl/luma_contrast_stretch.sv
// Per-frame luma contrast stretch: min/max statistics, serial Q8.8 gain divide, 3-stage stretch pipeline (optional LCS_BYPASS_PORT_EN adds stretch_bypass).
// Latency: 3 cycles on post_* outputs; new coefficients become active 18 cycles after a vsync rising edge.
// Backpressure: none (free-running video); a coefficient commit is dropped if pixels arrive while it is pending.
module luma_contrast_stretch #(
    parameter logic [7:0] MIN_RANGE = 8'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_hsync,
    input  logic       pre_frame_de,
    input  logic [7:0] img_y,
`ifdef LCS_BYPASS_PORT_EN
    input  logic       stretch_bypass,
`endif
    output logic       post_frame_vsync,
    output logic       post_frame_hsync,
    output logic       post_frame_de,
    output logic [7:0] post_img_y,
    output logic       coef_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        vsync_d;
    logic        vsync_rise;

    logic [7:0]  cur_min;
    logic [7:0]  cur_max;
    logic [7:0]  stat_min;
    logic [7:0]  stat_max;

    logic [7:0]  div_range;
    logic        div_pass;
    logic [3:0]  div_cnt;
    logic [7:0]  div_rem;
    logic [15:0] div_quo;
    logic [8:0]  rem_shift;
    logic        q_bit;
    logic [7:0]  rem_next;
    logic        de_seen;

    logic        div_step;
    logic        commit_en;

    logic [15:0] gain;
    logic [7:0]  off;
    logic [15:0] gain_new;
    logic [7:0]  off_new;

    logic        byp_in;
    logic [8:0]  diff9;

    logic        vs1, hs1, de1, byp1;
    logic [7:0]  d1, y1;
    logic        vs2, hs2, de2, byp2;
    logic [15:0] p2;
    logic [7:0]  y2;

`ifdef LCS_BYPASS_PORT_EN
    assign byp_in = stretch_bypass;
`else
    assign byp_in = 1'b0;
`endif

    assign vsync_rise = pre_frame_vsync & ~vsync_d;

    // vsync history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_d <= 1'b0;
        else        vsync_d <= pre_frame_vsync;
    end

    // running min/max of the current frame, snapshotted at each frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_min  <= 8'd255;
            cur_max  <= 8'd0;
            stat_min <= 8'd255;
            stat_max <= 8'd0;
        end else if (vsync_rise) begin
            stat_min <= cur_min;
            stat_max <= cur_max;
            cur_min  <= 8'd255;
            cur_max  <= 8'd0;
        end else if (pre_frame_de) begin
            if (img_y < cur_min) cur_min <= img_y;
            if (img_y > cur_max) cur_max <= img_y;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: any vsync edge (re)starts the divide with fresh stats
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (vsync_rise) state_nxt = S_DIV;
            S_DIV:    if (vsync_rise) state_nxt = S_DIV;
                      else if (div_cnt == 4'd15) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = vsync_rise ? S_DIV : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: divide enable and guarded coefficient commit
    always_comb begin
        div_step  = 1'b0;
        commit_en = 1'b0;
        if (state == S_DIV && !vsync_rise)
            div_step = 1'b1;
        if (state == S_COMMIT && !vsync_rise && !de_seen && !pre_frame_de)
            commit_en = 1'b1;
    end

    // one restoring-divide step of 65280 / range; quotient bits shift in behind the dividend
    always_comb begin
        div_range = stat_max - stat_min;
        div_pass  = (stat_max < stat_min) || (div_range < MIN_RANGE) || (div_range == 8'd0);
        rem_shift = {div_rem, div_quo[15]};
        q_bit     = (rem_shift >= {1'b0, div_range});
        rem_next  = q_bit ? (rem_shift[7:0] - div_range) : rem_shift[7:0];
        gain_new  = div_pass ? 16'd256 : div_quo;
        off_new   = div_pass ? 8'd0 : stat_min;
    end

    // divider state; pixels seen during the divide poison the pending commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 4'd0;
            div_rem <= 8'd0;
            div_quo <= 16'd0;
            de_seen <= 1'b0;
        end else if (vsync_rise) begin
            div_cnt <= 4'd0;
            div_rem <= 8'd0;
            div_quo <= 16'hFF00;
            de_seen <= 1'b0;
        end else begin
            if (div_step) begin
                div_cnt <= div_cnt + 4'd1;
                div_rem <= rem_next;
                div_quo <= {div_quo[14:0], q_bit};
            end
            if (state != S_IDLE && pre_frame_de)
                de_seen <= 1'b1;
        end
    end

    // active coefficients, reset to passthrough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain       <= 16'd256;
            off        <= 8'd0;
            coef_valid <= 1'b0;
        end else begin
            coef_valid <= commit_en;
            if (commit_en) begin
                gain <= gain_new;
                off  <= off_new;
            end
        end
    end

    assign diff9 = {1'b0, img_y} - {1'b0, off};

    // S1: subtract offset with clamp at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {vs1, hs1, de1, byp1} <= 4'b0;
            d1 <= 8'd0;
            y1 <= 8'd0;
        end else begin
            {vs1, hs1, de1, byp1} <= {pre_frame_vsync, pre_frame_hsync, pre_frame_de, byp_in};
            d1 <= diff9[8] ? 8'd0 : diff9[7:0];
            y1 <= img_y;
        end
    end

    // S2: Q8.8 multiply, keep integer part
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {vs2, hs2, de2, byp2} <= 4'b0;
            p2 <= 16'd0;
            y2 <= 8'd0;
        end else begin
            {vs2, hs2, de2, byp2} <= {vs1, hs1, de1, byp1};
            p2 <= 16'((24'(d1) * 24'(gain)) >> 8);
            y2 <= y1;
        end
    end

    // S3: saturate and blank outside active video
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_de    <= 1'b0;
            post_img_y       <= 8'd0;
        end else begin
            post_frame_vsync <= vs2;
            post_frame_hsync <= hs2;
            post_frame_de    <= de2;
            if (!de2)
                post_img_y <= 8'd0;
            else if (byp2)
                post_img_y <= y2;
            else
                post_img_y <= (p2 > 16'd255) ? 8'd255 : p2[7:0];
        end
    end

endmodule
